// File: rtl/interleaver_sched_if.sv
// Bus bundle for interleaver_sched: SIGNAL/DATA byte inputs, output stream
// toward the interleaver, and per-frame status.
interface interleaver_sched_if;
  logic [7:0]  s_sig_tdata;
  logic        s_sig_tvalid;
  logic        s_sig_tready;
  logic        s_sig_tlast;
  logic [7:0]  s_data_tdata;
  logic [3:0]  s_data_tuser;
  logic        s_data_tvalid;
  logic        s_data_tready;
  logic        s_data_tlast;
  logic [7:0]  m_axis_tdata;
  logic [3:0]  m_axis_tuser;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [11:0] sym_count;
  logic        err_rate;
  logic        err_sig;

  modport slave (
    input  s_sig_tdata, s_sig_tvalid, s_sig_tlast,
    input  s_data_tdata, s_data_tuser, s_data_tvalid, s_data_tlast,
    input  m_axis_tready,
    output s_sig_tready, s_data_tready,
    output m_axis_tdata, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
    output sym_count, err_rate, err_sig
  );

  modport master (
    output s_sig_tdata, s_sig_tvalid, s_sig_tlast,
    output s_data_tdata, s_data_tuser, s_data_tvalid, s_data_tlast,
    output m_axis_tready,
    input  s_sig_tready, s_data_tready,
    input  m_axis_tdata, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
    input  sym_count, err_rate, err_sig
  );
endinterface

// File: rtl/interleaver_sched.sv
// Sequences SIGNAL then DATA coded bytes into whole OFDM symbols for the
// interleaver, zero-padding the final DATA symbol.
module interleaver_sched (
  input  logic                aclk,
  input  logic                aresetn,
  interleaver_sched_if.slave  bus
);

  localparam logic [3:0] RATE_6M  = 4'hD;
  localparam logic [3:0] RATE_9M  = 4'hF;
  localparam logic [3:0] RATE_12M = 4'h5;
  localparam logic [3:0] RATE_18M = 4'h7;
  localparam logic [3:0] RATE_24M = 4'h9;
  localparam logic [3:0] RATE_36M = 4'hB;
  localparam logic [3:0] RATE_48M = 4'h1;
  localparam logic [3:0] RATE_54M = 4'h3;

  typedef enum logic [1:0] {IDLE, SIG, DATA, PAD} state_t;

  function automatic logic rate_known(input logic [3:0] r);
    return (r == RATE_6M)  || (r == RATE_9M)  || (r == RATE_12M) || (r == RATE_18M) ||
           (r == RATE_24M) || (r == RATE_36M) || (r == RATE_48M) || (r == RATE_54M);
  endfunction

  function automatic logic [5:0] sym_bytes(input logic [3:0] r);
    case (r)
      RATE_12M, RATE_18M: return 6'd12;
      RATE_24M, RATE_36M: return 6'd24;
      RATE_48M, RATE_54M: return 6'd36;
      default:            return 6'd6;
    endcase
  endfunction

  state_t      state, state_n;
  logic [5:0]  byte_cnt;
  logic [3:0]  rate;
  logic        rate_held;
  logic [11:0] sym_cnt;
  logic        err_rate_q, err_sig_q;
  logic [7:0]  m_data;
  logic [3:0]  m_user;
  logic        m_valid, m_last;

  logic        can_load, sym_end, sig_ready, data_ready, load, load_last;
  logic [7:0]  load_data;
  logic [3:0]  load_user, cur_rate;
  logic [5:0]  sz;

  // Rate used for this beat: latched value once held, otherwise the first
  // beat's tuser with unknown codes folded onto 6M.
  assign cur_rate = rate_held ? rate :
                    (rate_known(bus.s_data_tuser) ? bus.s_data_tuser : RATE_6M);
  assign sz       = sym_bytes(cur_rate);
  assign sym_end  = (byte_cnt == 6'(sz - 6'd1));
  assign can_load = ~m_valid | bus.m_axis_tready;

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n    = state;
    sig_ready  = 1'b0;
    data_ready = 1'b0;
    load       = 1'b0;
    load_data  = '0;
    load_user  = '0;
    load_last  = 1'b0;
    case (state)
      IDLE: if (bus.s_sig_tvalid) state_n = SIG;
      SIG: begin
        sig_ready = can_load;
        if (bus.s_sig_tvalid && can_load) begin
          load      = 1'b1;
          load_data = bus.s_sig_tdata;
          load_user = RATE_6M;
          if (byte_cnt == 6'd5) state_n = DATA;
        end
      end
      DATA: begin
        data_ready = can_load;
        if (bus.s_data_tvalid && can_load) begin
          load      = 1'b1;
          load_data = bus.s_data_tdata;
          load_user = cur_rate;
          load_last = bus.s_data_tlast & sym_end;
          if (bus.s_data_tlast) state_n = sym_end ? IDLE : PAD;
        end
      end
      PAD: begin
        if (can_load) begin
          load      = 1'b1;
          load_user = rate;
          load_last = sym_end;
          if (sym_end) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_data     <= '0;
      m_user     <= '0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      byte_cnt   <= '0;
      rate       <= '0;
      rate_held  <= 1'b0;
      sym_cnt    <= '0;
      err_rate_q <= 1'b0;
      err_sig_q  <= 1'b0;
    end else begin
      if (load) begin
        m_data  <= load_data;
        m_user  <= load_user;
        m_last  <= load_last;
        m_valid <= 1'b1;
      end else if (bus.m_axis_tready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end

      case (state)
        IDLE: if (bus.s_sig_tvalid) begin
          byte_cnt   <= '0;
          sym_cnt    <= '0;
          err_rate_q <= 1'b0;
          err_sig_q  <= 1'b0;
          rate_held  <= 1'b0;
          rate       <= RATE_6M;
        end
        SIG: if (load) begin
          // tlast must coincide exactly with the 6th byte; count alone advances
          err_sig_q <= err_sig_q | ((byte_cnt == 6'd5) != bus.s_sig_tlast);
          byte_cnt  <= (byte_cnt == 6'd5) ? '0 : byte_cnt + 6'd1;
          if (byte_cnt == 6'd5 && sym_cnt != '1) sym_cnt <= sym_cnt + 12'd1;
        end
        DATA, PAD: if (load) begin
          if (state == DATA && !rate_held) begin
            rate_held  <= 1'b1;
            rate       <= cur_rate;
            err_rate_q <= err_rate_q | ~rate_known(bus.s_data_tuser);
          end
          byte_cnt <= sym_end ? '0 : byte_cnt + 6'd1;
          if (sym_end && sym_cnt != '1) sym_cnt <= sym_cnt + 12'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.s_sig_tready  = sig_ready;
  assign bus.s_data_tready = data_ready;
  assign bus.m_axis_tdata  = m_data;
  assign bus.m_axis_tuser  = m_user;
  assign bus.m_axis_tvalid = m_valid;
  assign bus.m_axis_tlast  = m_last;
  assign bus.sym_count     = sym_cnt;
  assign bus.err_rate      = err_rate_q;
  assign bus.err_sig       = err_sig_q;

endmodule

// File: tb/tb_interleaver_sched.sv
// Directed self-checking bench for interleaver_sched: SIGNAL/DATA framing,
// padding, back-pressure, error flags and reset behaviour.
module tb_interleaver_sched;

  localparam logic [3:0] R6M  = 4'hD;
  localparam logic [3:0] R9M  = 4'hF;
  localparam logic [3:0] R12M = 4'h5;
  localparam logic [3:0] R24M = 4'h9;
  localparam logic [3:0] R48M = 4'h1;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic rdy = 1'b1;
  logic stall_mode = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   n_last = 0;

  logic [7:0] q_data[$];
  logic [3:0] q_user[$];
  logic       q_last[$];
  logic [7:0] e_data[$];
  logic [3:0] e_user[$];
  logic       e_last[$];

  interleaver_sched_if bus ();

  interleaver_sched dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  assign bus.m_axis_tready = rdy;

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    #1;
    rdy = stall_mode ? ~rdy : 1'b1;
  end

  // Output capture: a beat seen valid&ready mid-cycle transfers at the next edge
  always @(negedge aclk) begin
    if (aresetn && bus.m_axis_tvalid && bus.m_axis_tready) begin
      q_data.push_back(bus.m_axis_tdata);
      q_user.push_back(bus.m_axis_tuser);
      q_last.push_back(bus.m_axis_tlast);
      if (bus.m_axis_tlast) n_last++;
    end
  end

  task automatic clear_queues();
    q_data.delete(); q_user.delete(); q_last.delete();
    e_data.delete(); e_user.delete(); e_last.delete();
    n_last = 0;
  endtask

  task automatic expect_frame(input int ndata, input logic [3:0] eff_rate,
                              input int npad, input logic [7:0] base);
    for (int i = 0; i < 6; i++) begin
      e_data.push_back(8'hA0 + 8'(i)); e_user.push_back(R6M); e_last.push_back(1'b0);
    end
    for (int j = 0; j < ndata; j++) begin
      e_data.push_back(base + 8'(j)); e_user.push_back(eff_rate);
      e_last.push_back(npad == 0 && j == ndata - 1);
    end
    for (int k = 0; k < npad; k++) begin
      e_data.push_back(8'h00); e_user.push_back(eff_rate); e_last.push_back(k == npad - 1);
    end
  endtask

  // Starts and ends at a negedge; later DATA beats carry a bogus tuser that must be ignored.
  task automatic send_frame(input int ndata, input logic [3:0] rate,
                            input int sig_last, input logic [7:0] base);
    int t;
    for (int i = 0; i < 6; i++) begin
      bus.s_sig_tdata  = 8'hA0 + 8'(i);
      bus.s_sig_tlast  = (i == sig_last);
      bus.s_sig_tvalid = 1'b1;
      t = 0;
      while (!bus.s_sig_tready && t < 200) begin @(negedge aclk); t++; end
      if (!bus.s_sig_tready) begin
        checks++; errors++;
        $display("FAIL sig_handshake: byte %0d not accepted within 200 cycles", i);
        bus.s_sig_tvalid = 1'b0;
        return;
      end
      @(posedge aclk); @(negedge aclk);
    end
    bus.s_sig_tvalid = 1'b0;
    bus.s_sig_tlast  = 1'b0;
    for (int j = 0; j < ndata; j++) begin
      bus.s_data_tdata  = base + 8'(j);
      bus.s_data_tuser  = (j == 0) ? rate : 4'h0;
      bus.s_data_tlast  = (j == ndata - 1);
      bus.s_data_tvalid = 1'b1;
      t = 0;
      while (!bus.s_data_tready && t < 200) begin @(negedge aclk); t++; end
      if (!bus.s_data_tready) begin
        checks++; errors++;
        $display("FAIL data_handshake: byte %0d not accepted within 200 cycles", j);
        bus.s_data_tvalid = 1'b0;
        return;
      end
      @(posedge aclk); @(negedge aclk);
    end
    bus.s_data_tvalid = 1'b0;
    bus.s_data_tlast  = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int t = 0;
    while (n_last < n && t < 500) begin @(negedge aclk); t++; end
    checks++;
    if (n_last < n) begin
      errors++;
      $display("FAIL frame_end: saw %0d tlast beats, required %0d", n_last, n);
    end
    repeat (3) @(negedge aclk);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    bus.s_sig_tvalid = 1'b1;
    bus.s_sig_tlast = 1'b0; bus.s_sig_tdata = '0;
    bus.s_data_tvalid = 1'b0; bus.s_data_tlast = 1'b0;
    bus.s_data_tdata = '0; bus.s_data_tuser = '0;
    repeat (3) @(negedge aclk);
    checks++; if (bus.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", bus.m_axis_tvalid); end
    checks++; if (bus.m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b want 0", bus.m_axis_tlast); end
    checks++; if (bus.m_axis_tdata !== 8'h00) begin errors++; $display("FAIL rst_tdata: got %h want 00", bus.m_axis_tdata); end
    checks++; if (bus.m_axis_tuser !== 4'h0) begin errors++; $display("FAIL rst_tuser: got %h want 0", bus.m_axis_tuser); end
    checks++; if (bus.sym_count !== 12'd0) begin errors++; $display("FAIL rst_sym_count: got %0d want 0", bus.sym_count); end
    checks++; if ({bus.err_rate, bus.err_sig} !== 2'b00) begin errors++; $display("FAIL rst_err: got %b want 00", {bus.err_rate, bus.err_sig}); end
    checks++; if ({bus.s_sig_tready, bus.s_data_tready} !== 2'b00) begin errors++; $display("FAIL rst_tready: got %b want 00", {bus.s_sig_tready, bus.s_data_tready}); end
    bus.s_sig_tvalid = 1'b0;
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
  endtask

  task automatic test_rate24();
    clear_queues();
    expect_frame(24, R24M, 0, 8'h10);
    send_frame(24, R24M, 5, 8'h10);
    wait_frames(1);
    checks++;
    if (q_data.size() != 30) begin errors++; $display("FAIL r24_len: got %0d want 30", q_data.size()); end
    else for (int i = 0; i < 30; i++) begin
      checks++;
      if ({q_data[i], q_user[i], q_last[i]} !== {e_data[i], e_user[i], e_last[i]}) begin
        errors++; $display("FAIL r24_beat%0d: got %h/%h/%b want %h/%h/%b", i, q_data[i], q_user[i], q_last[i], e_data[i], e_user[i], e_last[i]);
      end
    end
    checks++; if (bus.sym_count !== 12'd2) begin errors++; $display("FAIL r24_sym_count: got %0d want 2", bus.sym_count); end
    checks++; if ({bus.err_rate, bus.err_sig} !== 2'b00) begin errors++; $display("FAIL r24_err: got %b want 00", {bus.err_rate, bus.err_sig}); end
    checks++; if ({bus.s_sig_tready, bus.s_data_tready} !== 2'b00) begin errors++; $display("FAIL idle_tready: got %b want 00", {bus.s_sig_tready, bus.s_data_tready}); end
  endtask

  task automatic test_pad48();
    clear_queues();
    expect_frame(40, R48M, 32, 8'h40);
    send_frame(40, R48M, 5, 8'h40);
    wait_frames(1);
    checks++;
    if (q_data.size() != 78) begin errors++; $display("FAIL pad48_len: got %0d want 78", q_data.size()); end
    else for (int i = 0; i < 78; i++) begin
      checks++;
      if ({q_data[i], q_user[i], q_last[i]} !== {e_data[i], e_user[i], e_last[i]}) begin
        errors++; $display("FAIL pad48_beat%0d: got %h/%h/%b want %h/%h/%b", i, q_data[i], q_user[i], q_last[i], e_data[i], e_user[i], e_last[i]);
      end
    end
    checks++; if (bus.sym_count !== 12'd3) begin errors++; $display("FAIL pad48_sym_count: got %0d want 3", bus.sym_count); end
  endtask

  task automatic test_stall();
    logic       done;
    logic       p_stall;
    logic [12:0] p_out;
    clear_queues();
    expect_frame(24, R24M, 0, 8'h10);
    stall_mode = 1'b1;
    done = 1'b0;
    p_stall = 1'b0;
    p_out = '0;
    fork
      begin
        send_frame(24, R24M, 5, 8'h10);
        wait_frames(1);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge aclk);
          if (p_stall) begin
            checks++;
            if ({bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast} !== {1'b1, p_out}) begin
              errors++; $display("FAIL stall_hold: got %b/%h want 1/%h", bus.m_axis_tvalid,
                {bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast}, p_out);
            end
          end
          p_stall = bus.m_axis_tvalid & ~bus.m_axis_tready;
          p_out = {bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast};
        end
      end
    join
    stall_mode = 1'b0;
    checks++;
    if (q_data.size() != 30) begin errors++; $display("FAIL stall_len: got %0d want 30", q_data.size()); end
    else for (int i = 0; i < 30; i++) begin
      checks++;
      if ({q_data[i], q_user[i], q_last[i]} !== {e_data[i], e_user[i], e_last[i]}) begin
        errors++; $display("FAIL stall_beat%0d: got %h/%h/%b want %h/%h/%b", i, q_data[i], q_user[i], q_last[i], e_data[i], e_user[i], e_last[i]);
      end
    end
    checks++; if (bus.sym_count !== 12'd2) begin errors++; $display("FAIL stall_sym_count: got %0d want 2", bus.sym_count); end
  endtask

  task automatic test_unknown_rate();
    clear_queues();
    expect_frame(5, R6M, 1, 8'h70);
    send_frame(5, 4'h0, 5, 8'h70);
    wait_frames(1);
    checks++;
    if (q_data.size() != 12) begin errors++; $display("FAIL unk_len: got %0d want 12", q_data.size()); end
    else for (int i = 0; i < 12; i++) begin
      checks++;
      if ({q_data[i], q_user[i], q_last[i]} !== {e_data[i], e_user[i], e_last[i]}) begin
        errors++; $display("FAIL unk_beat%0d: got %h/%h/%b want %h/%h/%b", i, q_data[i], q_user[i], q_last[i], e_data[i], e_user[i], e_last[i]);
      end
    end
    checks++; if (bus.err_rate !== 1'b1) begin errors++; $display("FAIL unk_err_rate: got %b want 1", bus.err_rate); end
    checks++; if (bus.err_sig !== 1'b0) begin errors++; $display("FAIL unk_err_sig: got %b want 0", bus.err_sig); end
    checks++; if (bus.sym_count !== 12'd2) begin errors++; $display("FAIL unk_sym_count: got %0d want 2", bus.sym_count); end
  endtask

  task automatic test_sig_err();
    clear_queues();
    expect_frame(6, R6M, 0, 8'h80);
    send_frame(6, R6M, 3, 8'h80);
    wait_frames(1);
    checks++;
    if (q_data.size() != 12) begin errors++; $display("FAIL sigerr_len: got %0d want 12", q_data.size()); end
    else for (int i = 0; i < 12; i++) begin
      checks++;
      if ({q_data[i], q_user[i], q_last[i]} !== {e_data[i], e_user[i], e_last[i]}) begin
        errors++; $display("FAIL sigerr_beat%0d: got %h/%h/%b want %h/%h/%b", i, q_data[i], q_user[i], q_last[i], e_data[i], e_user[i], e_last[i]);
      end
    end
    checks++; if (bus.err_sig !== 1'b1) begin errors++; $display("FAIL sigerr_flag: got %b want 1", bus.err_sig); end
    checks++; if (bus.err_rate !== 1'b0) begin errors++; $display("FAIL sigerr_err_rate: got %b want 0", bus.err_rate); end
    checks++; if (bus.sym_count !== 12'd2) begin errors++; $display("FAIL sigerr_sym_count: got %0d want 2", bus.sym_count); end
  endtask

  task automatic test_back_to_back();
    int n;
    clear_queues();
    expect_frame(12, R12M, 0, 8'h20);
    expect_frame(7, R9M, 5, 8'h50);
    send_frame(12, R12M, 5, 8'h20);
    send_frame(7, R9M, 5, 8'h50);
    wait_frames(2);
    n = e_data.size();
    checks++;
    if (q_data.size() != n) begin errors++; $display("FAIL b2b_len: got %0d want %0d", q_data.size(), n); end
    else for (int i = 0; i < n; i++) begin
      checks++;
      if ({q_data[i], q_user[i], q_last[i]} !== {e_data[i], e_user[i], e_last[i]}) begin
        errors++; $display("FAIL b2b_beat%0d: got %h/%h/%b want %h/%h/%b", i, q_data[i], q_user[i], q_last[i], e_data[i], e_user[i], e_last[i]);
      end
    end
    checks++; if (bus.sym_count !== 12'd3) begin errors++; $display("FAIL b2b_sym_count: got %0d want 3", bus.sym_count); end
  endtask

  task automatic test_reset_pad();
    int sz0;
    clear_queues();
    send_frame(40, R48M, 5, 8'h40);
    repeat (3) @(negedge aclk);
    aresetn = 1'b0;
    @(posedge aclk); @(negedge aclk);
    sz0 = q_data.size();
    checks++; if (sz0 <= 46) begin errors++; $display("FAIL rpad_started: got %0d beats want >46", sz0); end
    checks++; if (bus.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rpad_tvalid: got %b want 0", bus.m_axis_tvalid); end
    checks++; if (bus.sym_count !== 12'd0) begin errors++; $display("FAIL rpad_sym_count: got %0d want 0", bus.sym_count); end
    aresetn = 1'b1;
    repeat (10) @(negedge aclk);
    checks++; if (q_data.size() != sz0) begin errors++; $display("FAIL rpad_no_more: got %0d beats want %0d", q_data.size(), sz0); end
    checks++; if ({bus.m_axis_tvalid, bus.s_sig_tready, bus.s_data_tready} !== 3'b000) begin
      errors++; $display("FAIL rpad_idle: got %b want 000", {bus.m_axis_tvalid, bus.s_sig_tready, bus.s_data_tready});
    end
  endtask

  initial begin
    @(negedge aclk);
    test_reset();
    test_rate24();
    test_pad48();
    test_stall();
    test_unknown_rate();
    test_sig_err();
    test_back_to_back();
    test_reset_pad();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
